// File: rtl/ascon_perm_scheduler_if.sv
// ascon_perm_scheduler_if: requester/response bundle between client engines and the scheduler
interface ascon_perm_scheduler_if #(parameter int NREQ = 2) ();
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*320-1:0] req_state;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [319:0]        rsp_state;
  logic                rsp_err;
  modport master (
    output req_valid, req_state, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_state, rsp_err
  );
  modport slave (
    input  req_valid, req_state, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_state, rsp_err
  );
endinterface

// File: rtl/ascon_perm_scheduler.sv
// ascon_perm_scheduler: round-robin sharing of one Ascon p12 core among NREQ requesters
module ascon_perm_scheduler #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 31
) (
  input  logic                    clk,
  input  logic                    rst,
  ascon_perm_scheduler_if.slave   bus,
  output logic                    perm_start,
  output logic [319:0]            perm_state_in,
  input  logic [319:0]            perm_state_out,
  input  logic                    perm_done,
  output logic                    busy
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;
  state_t         state, next;
  logic [IDW-1:0] ptr, gid, gnt, idx, rsp_i;
  logic [7:0]     timer;
  logic [319:0]   job, rsp_st;
  logic           rsp_e, any, timed_out;
  assign any           = (|bus.req_valid) & ~rst;
  assign timed_out     = timer >= 8'(TIMEOUT - 1);
  assign perm_state_in = job;
  assign bus.rsp_id    = rsp_i;
  assign bus.rsp_state = rsp_st;
  assign bus.rsp_err   = rsp_e;
  // descending scan so the lowest offset from ptr wins
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      gnt = bus.req_valid[idx] ? idx : gnt;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = any ? LOAD : IDLE;
      LOAD:    next = RUN;
      RUN:     next = (perm_done || timed_out) ? RESP : RUN;
      RESP:    next = bus.rsp_ready ? IDLE : RESP;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    perm_start    = state == RUN;
    busy          = state != IDLE;
    bus.rsp_valid = state == RESP;
    bus.req_ready = (state == IDLE && any) ? NREQ'(1) << gnt : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= '0;
      gid    <= '0;
      job    <= '0;
      timer  <= '0;
      rsp_st <= '0;
      rsp_e  <= 1'b0;
      rsp_i  <= '0;
    end else begin
      if (state == IDLE && any) begin
        job <= bus.req_state[320*gnt +: 320];
        gid <= gnt;
      end
      if (state == LOAD) timer <= '0;
      if (state == RUN) begin
        timer <= (timer == 8'hff) ? timer : timer + 8'd1;
        if (perm_done || timed_out) begin
          rsp_st <= perm_done ? perm_state_out : '0;
          rsp_e  <= ~perm_done;
          rsp_i  <= gid;
        end
      end
      if (state == RESP && bus.rsp_ready) ptr <= (int'(gid) == NREQ - 1) ? '0 : gid + 1'b1;
    end
  end
endmodule

// File: tb/tb_ascon_perm_scheduler.sv
// tb_ascon_perm_scheduler: directed scheduler checks against a cycle model of the p12 core
module tb_ascon_perm_scheduler;
  localparam int NREQ = 2;
  localparam int IDW  = 1;
  localparam int TO   = 31;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         perm_start, busy, perm_done;
  logic         core_done = 1'b0;
  logic         stub = 1'b0;
  logic [3:0]   rc_cnt = 4'd0;
  logic [319:0] perm_state_in;
  logic [319:0] perm_state_out = '0;
  int           vectors = 0;
  int           miscompares = 0;
  typedef struct packed {
    logic [IDW-1:0] id;
    logic           err;
    logic [319:0]   st;
  } exp_t;
  exp_t sb[$];
  int   glog[$];
  always #5 clk = ~clk;
  ascon_perm_scheduler_if #(.NREQ(NREQ)) bus ();
  ascon_perm_scheduler #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .perm_start(perm_start), .perm_state_in(perm_state_in),
    .perm_state_out(perm_state_out), .perm_done(perm_done), .busy(busy)
  );
  assign perm_done = core_done & ~stub;
  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction
  function automatic logic [319:0] perm_round(input logic [319:0] s, input int i);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    x2 ^= 64'(((15 - i) << 4) | i);
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    x0 ^= ror(x0, 19) ^ ror(x0, 28);
    x1 ^= ror(x1, 61) ^ ror(x1, 39);
    x2 ^= ror(x2, 1)  ^ ror(x2, 6);
    x3 ^= ror(x3, 10) ^ ror(x3, 17);
    x4 ^= ror(x4, 7)  ^ ror(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction
  function automatic logic [319:0] p12(input logic [319:0] s);
    logic [319:0] r = s;
    for (int i = 0; i < 12; i++) r = perm_round(r, i);
    return r;
  endfunction
  function automatic logic [319:0] rnd320();
    logic [319:0] r = '0;
    for (int i = 0; i < 10; i++) r = {r[287:0], 32'($urandom)};
    return r;
  endfunction
  // core model: loads while start is low, one round per cycle while high, done after 12
  always @(posedge clk) begin
    if (perm_start === 1'b0) begin
      perm_state_out <= perm_state_in;
      rc_cnt         <= 4'd0;
      core_done      <= 1'b0;
    end else if (perm_start === 1'b1 && rc_cnt < 4'd12) begin
      perm_state_out <= perm_round(perm_state_out, int'(rc_cnt));
      rc_cnt         <= rc_cnt + 4'd1;
      core_done      <= rc_cnt == 4'd11;
    end
  end
  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask
  exp_t e;
  int   g;
  logic prev_start = 1'b0;
  int   low_cnt = 0;
  always @(negedge clk) if (!rst) begin
    if (bus.req_ready !== '0) begin
      check("grant_onehot", 320'($onehot(bus.req_ready)), 320'd1);
      g = 0;
      for (int k = 0; k < NREQ; k++) if (bus.req_ready[k]) g = k;
      glog.push_back(g);
      sb.push_back('{id: IDW'(g), err: stub, st: stub ? '0 : p12(bus.req_state[320*g +: 320])});
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      check("sb_nonempty", 320'(sb.size() != 0), 320'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rsp_id", 320'(bus.rsp_id), 320'(e.id));
        check("rsp_err", 320'(bus.rsp_err), 320'(e.err));
        check("rsp_state", bus.rsp_state, e.st);
      end
    end
    if (perm_start === 1'b1 && prev_start !== 1'b1) begin
      check("start_low_gap", 320'(low_cnt >= 2), 320'd1);
      check("start_done_clear", 320'(core_done), 320'd0);
    end
    low_cnt    = (perm_start === 1'b1) ? 0 : low_cnt + 1;
    prev_start = perm_start;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_job(input int i, input logic [319:0] st, output int runc);
    int n;
    runc = 0;
    bus.req_state[320*i +: 320] = st;
    bus.req_valid[i] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("grant_seen", 320'(bus.req_ready[i]), 320'd1);
    step();
    bus.req_valid[i] = 1'b0;
    @(negedge clk);
    check("load_start_low", 320'(perm_start), 320'd0);
    check("load_job_buf", perm_state_in, st);
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 400) begin
      runc += int'(perm_start);
      n++;
      @(negedge clk);
    end
    check("rsp_seen", 320'(bus.rsp_valid), 320'd1);
  endtask
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 320'(busy), 320'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [319:0] s1;
    int runc, n;
    bus.req_valid = '0;
    bus.req_state = '0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_perm_start", 320'(perm_start), 320'd0);
    check("rst_busy", 320'(busy), 320'd0);
    check("rst_rsp_valid", 320'(bus.rsp_valid), 320'd0);
    check("rst_rsp_err", 320'(bus.rsp_err), 320'd0);
    check("rst_rsp_id", 320'(bus.rsp_id), 320'd0);
    check("rst_rsp_state", bus.rsp_state, '0);
    check("rst_req_ready", 320'(bus.req_ready), 320'd0);
    check("rst_job_buf", perm_state_in, '0);
    step();
    rst = 1'b0;
    run_job(0, '0, runc);
    check("p12_run_cycles", 320'(runc), 320'd13);
    check("p12_zero_golden", bus.rsp_state, p12('0));
    step();
    wait_idle();
    // both requesters held valid through reset: strict alternation expected
    rst = 1'b1;
    glog.delete();
    bus.req_state = {rnd320(), rnd320()};
    bus.req_valid = 2'b11;
    @(negedge clk);
    check("rst_gated_ready", 320'(bus.req_ready), 320'd0);
    step();
    rst = 1'b0;
    n = 0;
    while (glog.size() < 4 && n < 300) begin
      step();
      n++;
    end
    bus.req_valid = '0;
    wait_idle();
    step();
    check("rr_grant_count", 320'(glog.size()), 320'd4);
    for (int k = 0; k < 4 && k < glog.size(); k++) check("rr_order", 320'(glog[k]), 320'(k % 2));
    check("rr_sb_drained", 320'(sb.size()), 320'd0);
    // held response: nothing moves while rsp_ready is low
    bus.rsp_ready = 1'b0;
    s1 = rnd320();
    run_job(1, s1, runc);
    step();
    bus.req_state[319:0] = rnd320();
    bus.req_valid[0] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("hold_rsp_valid", 320'(bus.rsp_valid), 320'd1);
      check("hold_rsp_id", 320'(bus.rsp_id), 320'd1);
      check("hold_rsp_state", bus.rsp_state, p12(s1));
      check("hold_perm_start", 320'(perm_start), 320'd0);
      check("hold_req_ready", 320'(bus.req_ready), 320'd0);
    end
    step();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("resp_no_grant", 320'(bus.req_ready), 320'd0);
    @(negedge clk);
    check("idle_grant_req0", 320'(bus.req_ready), 320'd1);
    step();
    bus.req_valid = '0;
    wait_idle();
    // stalled core: timeout after TO RUN cycles, then a normal job
    stub = 1'b1;
    run_job(1, rnd320(), runc);
    check("timeout_run_cycles", 320'(runc), 320'(TO));
    check("timeout_err", 320'(bus.rsp_err), 320'd1);
    check("timeout_state_zero", bus.rsp_state, '0);
    step();
    stub = 1'b0;
    wait_idle();
    run_job(0, rnd320(), runc);
    check("after_timeout_run_cycles", 320'(runc), 320'd13);
    check("after_timeout_err", 320'(bus.rsp_err), 320'd0);
    step();
    wait_idle();
    // reset mid-RUN with pointer at 1: next grant must return to req0
    bus.req_state[639:320] = rnd320();
    bus.req_valid[1] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready[1] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("midrun_grant", 320'(bus.req_ready), 320'd2);
    step();
    bus.req_valid = '0;
    repeat (5) step();
    check("midrun_running", 320'(perm_start), 320'd1);
    rst = 1'b1;
    sb.delete();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("midrun_perm_start", 320'(perm_start), 320'd0);
    check("midrun_busy", 320'(busy), 320'd0);
    check("midrun_rsp_valid", 320'(bus.rsp_valid), 320'd0);
    step();
    bus.req_valid = 2'b11;
    @(negedge clk);
    check("midrun_ptr_reset", 320'(bus.req_ready), 320'd1);
    step();
    bus.req_valid = '0;
    wait_idle();
    step();
    check("final_sb_drained", 320'(sb.size()), 320'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
